seg7_page_scanner: RTL and testbench

- Parametrised successor to the fixed 4-digit hour/minute 7-segment driver.
- Time-multiplexes N_DIGITS common-anode digits across NUM_PAGES selectable pages of BCD data, e.g. time / date / year from the clock-calendar core.
- Page selection is manual (button) or automatic (scroll every HOLD_TICKS seconds).
- Per-digit blink supports set-mode feedback. Sits between the clock-calendar core and the board display pins.

---
 rtl/seg7_page_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_seg7_page_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_page_scanner.sv
// -----------------------------------------------------------------------------
// seg7_page_scanner
//
// Purpose:
//   Time-multiplexes N_DIGITS common-anode 7-segment digits across NUM_PAGES
//   pages of packed BCD data. The page is advanced by a push button or, in
//   auto-scroll mode, every HOLD_TICKS pulses of tick_1Hz. Per-digit blinking
//   (0.5 Hz) gives set-mode feedback.
//
// Optional feature:
//   SEG7_LZ_BLANK_EN - when defined, leading zeros of each page are blanked
//                      (digit 0 is always shown).
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   tick_1Hz    in   one-cycle 1 Hz strobe (synchronous)
//   page_btn    in   asynchronous button, rising edge advances the page
//   auto_scroll in   1 = automatic page scrolling
//   blink_mask  in   per-digit blink enable
//   page_data   in   packed BCD, page p digit d at [(p*N_DIGITS+d)*4 +: 4]
//   page_idx    out  currently displayed page
//   seg         out  active-low segments, seg[0]=a .. seg[6]=g
//   digit       out  active-low anode enables, one-hot-low
// -----------------------------------------------------------------------------
module seg7_page_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int NUM_PAGES   = 3,
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_TICKS  = 5,
    localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic                            tick_1Hz,
    input  logic [NUM_PAGES*N_DIGITS*4-1:0] page_data,
    input  logic                            page_btn,
    input  logic                            auto_scroll,
    input  logic [N_DIGITS-1:0]             blink_mask,
    output logic [PW-1:0]                   page_idx,
    output logic [0:6]                      seg,
    output logic [N_DIGITS-1:0]             digit
);

    localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } state_t;

    // Active-low glyphs, bit order a..g from left to right.
    function automatic logic [0:6] seg7_decode(input logic [3:0] nib);
        logic [0:6] g;
        case (nib)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b1111110;   // non-BCD shows a dash
        endcase
        return g;
    endfunction

    logic              r_btn_s1;
    logic              r_btn_s2;
    logic              r_btn_d;
    logic [CW-1:0]     r_refresh_cnt;
    logic [SW-1:0]     r_scan;
    state_t            r_state;
    logic [PW-1:0]     r_page;
    logic [HW-1:0]     r_hold;
    logic              r_phase;
    logic [0:6]        r_seg;
    logic [N_DIGITS-1:0] r_digit;

    logic              w_press;
    logic              w_strobe;
    state_t            w_next_state;
    logic [PW-1:0]     w_page_inc;
    logic [PW-1:0]     w_page_next;
    logic [HW-1:0]     w_hold_next;
    logic              w_expire;
    logic [3:0]        w_nib;
    logic              w_lz;
    logic              w_blank;
    logic [0:6]        w_seg;
    logic [N_DIGITS-1:0] w_digit;

    // Button: two-FF synchroniser followed by rising-edge detect.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_d  <= 1'b0;
        end else begin
            r_btn_s1 <= page_btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
        end
    end

    assign w_press = r_btn_s2 & ~r_btn_d;

    // Refresh prescaler and scan index.
    assign w_strobe = (r_refresh_cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_refresh_cnt <= '0;
            r_scan        <= '0;
        end else if (w_strobe) begin
            r_refresh_cnt <= '0;
            r_scan        <= (r_scan == SW'(N_DIGITS - 1)) ? '0 : r_scan + SW'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + CW'(1);
        end
    end

    // Page FSM state register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_state <= S_MANUAL;
            r_page  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            r_page  <= w_page_next;
            r_hold  <= w_hold_next;
        end
    end

    // With a single page the wrap compare is always true, pinning page 0.
    assign w_page_inc = (r_page == PW'(NUM_PAGES - 1)) ? '0 : r_page + PW'(1);

    // Hold counting only runs while both the registered state and the live
    // auto_scroll agree on AUTO; leaving AUTO clears the counter at once and
    // entering AUTO starts from the zero that MANUAL keeps in place.
    always_comb begin
        w_next_state = auto_scroll ? S_AUTO : S_MANUAL;
        w_page_next  = r_page;
        w_hold_next  = '0;
        w_expire     = 1'b0;
        if (r_state == S_AUTO && auto_scroll) begin
            w_hold_next = r_hold;
            if (tick_1Hz) begin
                if (r_hold == HW'(HOLD_TICKS - 1)) begin
                    w_expire = 1'b1;
                end else begin
                    w_hold_next = r_hold + HW'(1);
                end
            end
        end
        // Press and expiry together still advance a single page.
        if (w_press || w_expire) begin
            w_page_next = w_page_inc;
            w_hold_next = '0;
        end
    end

    // Blink phase: toggles per second, 0.5 Hz period.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_phase <= 1'b0;
        end else if (tick_1Hz) begin
            r_phase <= ~r_phase;
        end
    end

    // Digit selection and glyph decode from live page data.
    always_comb begin
        w_nib = page_data[(int'(r_page) * N_DIGITS + int'(r_scan)) * 4 +: 4];
`ifdef SEG7_LZ_BLANK_EN
        // Blank a digit when it and every more-significant digit are zero.
        w_lz = (r_scan != '0);
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(r_scan) &&
                page_data[(int'(r_page) * N_DIGITS + j) * 4 +: 4] != 4'd0) begin
                w_lz = 1'b0;
            end
        end
`else
        w_lz = 1'b0;
`endif
        w_blank = (r_phase & blink_mask[r_scan]) | w_lz;
        w_seg   = w_blank ? 7'b1111111 : seg7_decode(w_nib);
        w_digit = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_digit[i] = (r_scan != SW'(i));
        end
    end

    // Output registers; the anode stays driven even when the glyph is blanked.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_seg   <= 7'b1111111;
            r_digit <= '1;
        end else begin
            r_seg   <= w_seg;
            r_digit <= w_digit;
        end
    end

    assign seg      = r_seg;
    assign digit    = r_digit;
    assign page_idx = r_page;

endmodule

// File: tb/tb_seg7_page_scanner.sv
module tb_seg7_page_scanner;

    localparam int ND = 4;
    localparam int NP = 3;
    localparam int RD = 4;
    localparam int HT = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] DS = 7'b1111110;
    localparam logic [6:0] BK = 7'b1111111;
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] LZ = BK;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic                  clk_100MHz = 1'b0;
    logic                  reset = 1'b0;
    logic                  tick_1Hz = 1'b0;
    logic [NP*ND*4-1:0]    page_data = '0;
    logic                  page_btn = 1'b0;
    logic                  auto_scroll = 1'b0;
    logic [ND-1:0]         blink_mask = '0;
    logic [1:0]            page_idx;
    logic [0:6]            seg;
    logic [ND-1:0]         digit;

    int checks = 0;
    int failures = 0;
    logic tb_phase = 1'b0;

    typedef struct {
        logic [15:0]      p0;
        logic [3:0]       mask;
        logic             phase;
        logic [3:0][6:0]  exp;   // index = digit position
    } vec_t;

    vec_t vecs[9];

    seg7_page_scanner #(
        .N_DIGITS(ND), .NUM_PAGES(NP), .REFRESH_DIV(RD), .HOLD_TICKS(HT)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick_1Hz   (tick_1Hz),
        .page_data  (page_data),
        .page_btn   (page_btn),
        .auto_scroll(auto_scroll),
        .blink_mask (blink_mask),
        .page_idx   (page_idx),
        .seg        (seg),
        .digit      (digit)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100MHz);
        tick_1Hz = 1'b1;
        @(negedge clk_100MHz);
        tick_1Hz = 1'b0;
        tb_phase = ~tb_phase;
    endtask

    task automatic find_slot(input int s, output logic ok);
        logic [3:0] want;
        want = ~(4'b0001 << s);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_100MHz);
            @(negedge clk_100MHz);
            if (digit === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_check(input logic [1:0] exp_old, input logic [1:0] exp_new);
        @(negedge clk_100MHz);
        page_btn = 1'b1;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        chk("press_before", page_idx, exp_old);
        @(negedge clk_100MHz);
        chk("press_after", page_idx, exp_new);
        repeat (2) @(negedge clk_100MHz);
        page_btn = 1'b0;
        repeat (4) @(negedge clk_100MHz);
    endtask

    initial begin
        logic [3:0][6:0] rs;
        logic ok;
        logic [3:0] dexp;

        vecs[0] = '{p0: 16'h1234, mask: 4'b0000, phase: 1'b0, exp: {S1, S2, S3, S4}};
        vecs[1] = '{p0: 16'h5678, mask: 4'b0000, phase: 1'b0, exp: {S5, S6, S7, S8}};
        vecs[2] = '{p0: 16'h9AC0, mask: 4'b0000, phase: 1'b0, exp: {S9, DS, DS, S0}};
        vecs[3] = '{p0: 16'h0050, mask: 4'b0000, phase: 1'b0, exp: {LZ, LZ, S5, S0}};
        vecs[4] = '{p0: 16'h1234, mask: 4'b0011, phase: 1'b1, exp: {S1, S2, BK, BK}};
        vecs[5] = '{p0: 16'h1234, mask: 4'b0011, phase: 1'b0, exp: {S1, S2, S3, S4}};
        vecs[6] = '{p0: 16'h0007, mask: 4'b0000, phase: 1'b0, exp: {LZ, LZ, LZ, S7}};
        vecs[7] = '{p0: 16'h0000, mask: 4'b0000, phase: 1'b0, exp: {LZ, LZ, LZ, S0}};
        vecs[8] = '{p0: 16'h0007, mask: 4'b1000, phase: 1'b1, exp: {BK, LZ, LZ, S7}};

        page_data = {16'h9999, 16'h5678, 16'h1234};

        // Reset state and scan order after release
        repeat (3) @(negedge clk_100MHz);
        chk("rst_digit", digit, 4'b1111);
        chk("rst_seg", seg, BK);
        chk("rst_page", page_idx, 2'd0);
        reset = 1'b1;
        rs = {S1, S2, S3, S4};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_100MHz);
            dexp = ~(4'b0001 << (k / 4));
            chk("scan_digit", digit, dexp);
            chk("scan_seg", seg, rs[k / 4]);
        end

        // Table of display patterns on page 0
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_100MHz);
            page_data[15:0] = vecs[i].p0;
            blink_mask = vecs[i].mask;
            if (tb_phase != vecs[i].phase) tick();
            for (int s = 0; s < 4; s++) begin
                find_slot(s, ok);
                chk("slot_found", ok, 1'b1);
                chk($sformatf("vec%0d_d%0d", i, s), seg, vecs[i].exp[s]);
            end
        end
        @(negedge clk_100MHz);
        blink_mask = '0;

        // Manual paging; ticks ignored
        press_check(2'd0, 2'd1);
        press_check(2'd1, 2'd2);
        press_check(2'd2, 2'd0);
        tick();
        tick();
        tick();
        chk("manual_tick", page_idx, 2'd0);
        press_check(2'd0, 2'd1);

        // Async reset mid-slot
        @(posedge clk_100MHz);
        #2 reset = 1'b0;
        #1;
        chk("async_digit", digit, 4'b1111);
        chk("async_seg", seg, BK);
        chk("async_page", page_idx, 2'd0);
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b1;
        tb_phase = 1'b0;
        repeat (2) @(negedge clk_100MHz);

        // Auto scroll every HT ticks
        auto_scroll = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        tick(); chk("auto_t1", page_idx, 2'd0);
        tick(); chk("auto_t2", page_idx, 2'd1);
        tick(); chk("auto_t3", page_idx, 2'd1);
        tick(); chk("auto_t4", page_idx, 2'd2);
        tick(); chk("auto_t5", page_idx, 2'd2);
        tick(); chk("auto_wrap", page_idx, 2'd0);

        // Press coinciding with hold expiry advances exactly one page
        tick(); chk("coinc_pre", page_idx, 2'd0);
        @(negedge clk_100MHz);
        page_btn = 1'b1;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        tick_1Hz = 1'b1;
        @(negedge clk_100MHz);
        tick_1Hz = 1'b0;
        tb_phase = ~tb_phase;
        chk("coinc_page", page_idx, 2'd1);
        repeat (2) @(negedge clk_100MHz);
        page_btn = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        chk("coinc_settle", page_idx, 2'd1);
        tick(); chk("coinc_cleared", page_idx, 2'd1);
        tick(); chk("coinc_next", page_idx, 2'd2);

        // AUTO -> MANUAL holds the page and clears the counter
        tick(); chk("a2m_pre", page_idx, 2'd2);
        @(negedge clk_100MHz);
        auto_scroll = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        chk("a2m_hold", page_idx, 2'd2);
        tick(); tick();
        chk("a2m_ticks", page_idx, 2'd2);

        // MANUAL -> AUTO counts from zero
        @(negedge clk_100MHz);
        auto_scroll = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        tick(); chk("m2a_t1", page_idx, 2'd2);
        tick(); chk("m2a_t2", page_idx, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
